pht_counter_table: RTL
======================

PHT_COUNTER_TABLE -- requirements
Module: pht_counter_table

Interface
REQ-001 SHALL have parameter CTR_W, default 2, counter width in bits (legal 1..8).
REQ-002 SHALL have parameter IDX_W, default 6, index width; DEPTH = 2**IDX_W entries.
REQ-003 SHALL have parameter INIT_VAL, default 2**(CTR_W-1)-1 (weakly not-taken), entry value after initialisation.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port flush  input  1  pulse; re-initialises whole table.
REQ-007 SHALL have port ready  output  1  high when table is initialised and accepting requests.
REQ-008 SHALL have port rd_valid  input  1  read request this cycle.
REQ-009 SHALL have port rd_idx  input  IDX_W  read entry index.
REQ-010 SHALL have port rd_data_valid  output  1  registered read response valid.
REQ-011 SHALL have port rd_ctr  output  CTR_W  registered counter value of read entry.
REQ-012 SHALL have port rd_pred  output  1  prediction, equal to rd_ctr[CTR_W-1].
REQ-013 SHALL have port upd_valid  input  1  update request this cycle.
REQ-014 SHALL have port upd_idx  input  IDX_W  entry to update.
REQ-015 SHALL have port upd_taken  input  1  resolved outcome, 1 taken, 0 not-taken.

Function
REQ-016 SHALL implement FSM with states INIT and RUN; ready = 1 only in RUN.
REQ-017 In INIT, SHALL write INIT_VAL to entry init_ptr each cycle, init_ptr counting 0..DEPTH-1; after writing DEPTH-1 SHALL enter RUN next cycle (INIT lasts exactly DEPTH cycles).
REQ-018 In INIT, rd_valid and upd_valid SHALL be ignored; rd_data_valid SHALL stay 0.
REQ-019 flush asserted in any state SHALL enter INIT with init_ptr = 0 on next edge; flush in INIT restarts the sweep; flush wins over a same-cycle update, which is dropped.
REQ-020 In RUN, rd_valid at cycle t SHALL give rd_data_valid = 1 at t+1 with rd_ctr = entry value; rd_data_valid = 0 otherwise; rd_ctr/rd_pred hold last value when not valid.
REQ-021 In RUN, upd_valid SHALL write entry upd_idx at the edge: taken -> value+1 saturating at 2**CTR_W-1; not-taken -> value-1 saturating at 0.
REQ-022 Saturation SHALL never wrap: taken at max keeps max; not-taken at 0 keeps 0.
REQ-023 Read and update to different indices in same cycle SHALL both complete independently.
REQ-024 Read and update to same index in same cycle SHALL follow REQ-037/REQ-038.
REQ-025 Back-to-back updates to same index SHALL accumulate (each sees previous write).
REQ-026 Throughput SHALL be one read and one update per cycle, no stalls in RUN.

Reset
REQ-027 rst_n low SHALL asynchronously force state = INIT, init_ptr = 0, ready = 0, rd_data_valid = 0, rd_ctr = 0, rd_pred = 0.
REQ-028 Counter array SHALL NOT be reset directly; it SHALL be cleared by the INIT sweep after rst_n deasserts.
REQ-029 Reset asserted mid-INIT or mid-RUN SHALL abort all activity; sweep restarts from 0 after release.
REQ-030 rst_n deassertion is assumed synchronised externally to clk.

Configuration
REQ-031 Macro PHT_COUNTER_TABLE_BYPASS_EN SHALL control same-index read/update forwarding.
REQ-032 (covered by REQ-037/038.)
REQ-037 With macro defined: same-cycle same-index read SHALL return post-update (saturated) value.
REQ-038 Without macro: same-cycle same-index read SHALL return pre-update value; no forwarding logic instantiated.

Verification (CTR_W=2, IDX_W=4, INIT_VAL=1)
REQ-033 Release rst_n -> ready = 0 for exactly 16 cycles, then 1; read of every index returns rd_ctr = 1, rd_pred = 0.
REQ-034 Idx 5: three taken updates then read -> values 2,3,3 (saturated), rd_ctr = 3, rd_pred = 1; then four not-taken -> 2,1,0,0, read returns 0.
REQ-035 Idx 7 at 1: read and taken update same cycle -> rd_ctr = 2 with PHT_COUNTER_TABLE_BYPASS_EN, rd_ctr = 1 without; following read returns 2 in both builds.
REQ-036 Idx 3 at 3, flush with upd_valid same cycle -> ready = 0 for 16 cycles, update dropped, then idx 3 reads 1.
REQ-039 rst_n pulsed low at sweep cycle 8 -> ready/rd_data_valid drop immediately; after release ready rises after 16 full cycles.
REQ-040 rd_valid and upd_valid during INIT -> no rd_data_valid, table unchanged (all entries 1 after ready).

Source files
------------

// File: rtl/pht_counter_table.sv
`default_nettype none
// ============================================================================
// Module  : pht_counter_table
// Brief   : Pattern-history table of saturating branch counters, cleared by an
//           INIT sweep; optional same-index read/update forwarding is enabled
//           by defining PHT_COUNTER_TABLE_BYPASS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module pht_counter_table #(
    parameter int CTR_W    = 2,
    parameter int IDX_W    = 6,
    parameter int INIT_VAL = 2**(CTR_W-1)-1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    output logic             ready,
    input  logic             rd_valid,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_data_valid,
    output logic [CTR_W-1:0] rd_ctr,
    output logic             rd_pred,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int               DEPTH     = 2**IDX_W;
    localparam logic [CTR_W-1:0] c_initVal = CTR_W'(INIT_VAL);
    localparam logic [CTR_W-1:0] c_ctrMax  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] c_ctrMin  = '0;
    localparam logic [IDX_W-1:0] c_lastIdx = {IDX_W{1'b1}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_initPtr;
    logic             r_ready;
    logic             r_rdDataValid;
    logic [CTR_W-1:0] r_rdCtr;
    logic [CTR_W-1:0] r_ctrMem [DEPTH];

    logic             w_updEn;
    logic [CTR_W-1:0] w_updCur;
    logic [CTR_W-1:0] w_updNext;
    logic [CTR_W-1:0] w_rdVal;

    // A flush in the same cycle takes priority, so the update is dropped.
    assign w_updEn  = (r_state == ST_RUN) && upd_valid && !flush;
    assign w_updCur = r_ctrMem[upd_idx];

    always_comb begin
        w_updNext = w_updCur;
        if (upd_taken) begin
            if (w_updCur != c_ctrMax) w_updNext = w_updCur + 1'b1;
        end else begin
            if (w_updCur != c_ctrMin) w_updNext = w_updCur - 1'b1;
        end
    end

`ifdef PHT_COUNTER_TABLE_BYPASS_EN
    assign w_rdVal = (w_updEn && (upd_idx == rd_idx)) ? w_updNext : r_ctrMem[rd_idx];
`else
    assign w_rdVal = r_ctrMem[rd_idx];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_INIT;
            r_initPtr     <= '0;
            r_ready       <= 1'b0;
            r_rdDataValid <= 1'b0;
            r_rdCtr       <= '0;
        end else if (flush) begin
            r_state       <= ST_INIT;
            r_initPtr     <= '0;
            r_ready       <= 1'b0;
            r_rdDataValid <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_rdDataValid <= 1'b0;
                    r_initPtr     <= r_initPtr + 1'b1;
                    if (r_initPtr == c_lastIdx) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_rdDataValid <= rd_valid;
                    if (rd_valid) r_rdCtr <= w_rdVal;
                end
                default: begin
                    r_state   <= ST_INIT;
                    r_initPtr <= '0;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // The array has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_ctrMem[r_initPtr] <= c_initVal;
        end else if (w_updEn) begin
            r_ctrMem[upd_idx] <= w_updNext;
        end
    end

    assign ready         = r_ready;
    assign rd_data_valid = r_rdDataValid;
    assign rd_ctr        = r_rdCtr;
    assign rd_pred       = r_rdCtr[CTR_W-1];

endmodule
`default_nettype wire
